// File: rtl/test_block_if.sv
// Stimulus/result bundle for test_block: mode word, width/delay word, data bit
// and the registered result bit.
interface test_block_if;
   logic [31:0] FUNC;
   logic [1:0]  A;
   logic        INPA_i;
   logic        OUT_o;

   modport master (output FUNC, output A, output INPA_i, input OUT_o);
   modport slave  (input FUNC, input A, input INPA_i, output OUT_o);
endinterface

// File: rtl/test_block.sv
// Single-bit timing-test leaf: pass, invert, retriggerable pulse stretch, or
// 2..33 cycle delay of INPA_i, selected by A; OUT_o is always registered.
module test_block (
   input  logic        clk_i,
   input  logic        reset_n_i,
   test_block_if.slave bus
);

   logic        prev_inpa;
   logic [1:0]  prev_a;
   logic [31:0] cnt;
   logic [31:0] cnt_nxt;
   logic [31:0] cnt_eff;
   logic [31:0] sr;
   logic        out_q;
   logic        out_nxt;
   logic        rise;
   logic        mode_chg;

   // Counter reload for a pulse of max(width,1) cycles: the load cycle itself
   // drives OUT_o high, so the counter only has to cover the remainder.
   function automatic logic [31:0] pulse_load(input logic [31:0] width);
      return (width == 32'd0) ? 32'd0 : width - 32'd1;
   endfunction

   always_comb begin
      rise     = bus.INPA_i & ~prev_inpa;
      mode_chg = (bus.A != prev_a);
      // A mode change discards any pulse in progress in the same cycle.
      cnt_eff  = mode_chg ? 32'd0 : cnt;
      out_nxt  = 1'b0;
      cnt_nxt  = 32'd0;
      case (bus.A)
         2'd0: out_nxt = bus.INPA_i;
         2'd1: out_nxt = ~bus.INPA_i;
         2'd2: begin
            if (rise) begin
               cnt_nxt = pulse_load(bus.FUNC);
               out_nxt = 1'b1;
            end else if (cnt_eff != 32'd0) begin
               cnt_nxt = cnt_eff - 32'd1;
               out_nxt = 1'b1;
            end
         end
         default: out_nxt = sr[bus.FUNC[4:0]];
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         prev_inpa <= 1'b0;
         prev_a    <= 2'd0;
         cnt       <= 32'd0;
         sr        <= 32'd0;
         out_q     <= 1'b0;
      end else begin
         prev_inpa <= bus.INPA_i;
         prev_a    <= bus.A;
         cnt       <= cnt_nxt;
         sr        <= {sr[30:0], bus.INPA_i};
         out_q     <= out_nxt;
      end
   end

   assign bus.OUT_o = out_q;

endmodule

// File: tb/tb_test_block.sv
// Bench for test_block: directed vector table, reset/long-pulse sequences,
// then randomized stimulus against a cycle-history reference model.
module tb_test_block;

   logic clk_i;
   logic reset_n_i;

   test_block_if bus ();

   test_block dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .bus       (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_vec;
   int n_err;

   typedef struct {
      logic [1:0]  a;
      logic [31:0] f;
      logic        in;
      logic        exp;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic [1:0] a, input logic [31:0] f,
                      input logic in, input logic exp);
      vec_t v;
      v.a = a; v.f = f; v.in = in; v.exp = exp;
      vt.push_back(v);
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: OUT_o=%0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, then look at OUT_o just after the edge.
   task automatic step(input logic [1:0] a, input logic [31:0] f,
                       input logic in, input logic exp, input string name);
      bus.A = a; bus.FUNC = f; bus.INPA_i = in;
      @(posedge clk_i); #1;
      check(name, bus.OUT_o, exp);
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      bus.A = 2'd0; bus.FUNC = 32'd0; bus.INPA_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 check("reset_state", bus.OUT_o, 1'b0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   // Reference model: remembers every input since reset and the cycle at
   // which the current stretched pulse ends.
   longint m_t;
   bit     m_hist[$];
   bit     m_pin;
   logic [1:0] m_pa;
   longint m_pend;

   task automatic mdl_reset();
      m_t = 0; m_hist.delete(); m_pin = 0; m_pa = 2'd0; m_pend = -1;
   endtask

   function automatic logic mdl_step(input logic [1:0] a, input logic [31:0] f,
                                     input logic in);
      logic   r;
      longint fl;
      longint idx;
      r = 1'b0;
      fl = 0;
      fl[31:0] = f;
      if (a == 2'd2) begin
         if (in && !m_pin)      m_pend = m_t + ((fl == 0) ? 1 : fl);
         else if (a != m_pa)    m_pend = m_t;
         r = (m_t + 1 <= m_pend);
      end else if (a == 2'd0) begin
         r = in;
      end else if (a == 2'd1) begin
         r = ~in;
      end else begin
         idx = m_t - longint'(f[4:0]) - 1;
         r = (idx >= 0) ? m_hist[idx] : 1'b0;
      end
      m_hist.push_back(in);
      m_pin = in; m_pa = a; m_t++;
      return r;
   endfunction

   initial begin
      logic [1:0]  ra;
      logic [31:0] rf;
      logic        rin;
      logic        rexp;

      n_vec = 0;
      n_err = 0;

      // ---------------- directed table ----------------
      // pass
      add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 0, 1, 1); add(0, 0, 1, 1);
      add(0, 0, 1, 1); add(0, 0, 0, 0); add(0, 0, 0, 0);
      // invert
      add(1, 0, 0, 1); add(1, 0, 0, 1); add(1, 0, 1, 0); add(1, 0, 0, 1);
      // stretch, FUNC=5
      add(2, 5, 0, 0); add(2, 5, 1, 1);
      for (int i = 0; i < 4; i++) add(2, 5, 0, 1);
      add(2, 5, 0, 0); add(2, 5, 0, 0);
      // stretch, FUNC=0 -> one cycle
      add(2, 0, 1, 1); add(2, 0, 0, 0); add(2, 0, 0, 0);
      // retrigger, FUNC=4: rises two cycles apart -> six high cycles
      add(2, 4, 1, 1); add(2, 4, 0, 1); add(2, 4, 1, 1);
      add(2, 4, 0, 1); add(2, 4, 0, 1); add(2, 4, 0, 1); add(2, 4, 0, 0);
      // level held high is a single rise
      for (int i = 0; i < 4; i++) add(2, 4, 1, 1);
      add(2, 4, 1, 0); add(2, 4, 0, 0);
      // FUNC change mid-pulse has no effect
      add(2, 3, 1, 1); add(2, 100, 0, 1); add(2, 100, 0, 1); add(2, 100, 0, 0);
      // flush the delay line with zeros
      for (int i = 0; i < 6; i++) add(0, 0, 0, 0);
      // delay FUNC=3 (latency 5), then FUNC=0x23 identical
      add(3, 3, 1, 0);
      for (int i = 0; i < 3; i++) add(3, 3, 0, 0);
      add(3, 3, 0, 1); add(3, 3, 0, 0);
      add(3, 32'h23, 1, 0);
      for (int i = 0; i < 3; i++) add(3, 32'h23, 0, 0);
      add(3, 32'h23, 0, 1); add(3, 32'h23, 0, 0);
      // delay FUNC=0 (latency 2)
      add(3, 0, 1, 0); add(3, 0, 0, 1); add(3, 0, 0, 0);
      // delay FUNC=31 (latency 33)
      for (int i = 0; i < 32; i++) add(0, 0, 0, 0);
      add(3, 31, 1, 0);
      for (int i = 0; i < 31; i++) add(3, 31, 0, 0);
      add(3, 31, 0, 1); add(3, 31, 0, 0);
      // switch 2->0 mid-pulse, then back to 2 with no new rise
      add(2, 10, 0, 0); add(2, 10, 1, 1); add(2, 10, 0, 1); add(2, 10, 0, 1);
      add(0, 10, 0, 0); add(0, 10, 1, 1); add(2, 10, 1, 0); add(2, 10, 0, 0);

      do_reset();
      for (int i = 0; i < vt.size(); i++)
         step(vt[i].a, vt[i].f, vt[i].in, vt[i].exp, $sformatf("table[%0d]", i));

      // ---------------- async reset mid-pulse ----------------
      step(2, 4, 1, 1, "pre_reset_rise");
      step(2, 4, 0, 1, "pre_reset_hold");
      #3 reset_n_i = 1'b0;
      #1 check("async_reset_drop", bus.OUT_o, 1'b0);
      @(posedge clk_i); #1 check("reset_hold", bus.OUT_o, 1'b0);
      @(negedge clk_i);
      bus.A = 2'd2; bus.FUNC = 32'd2; bus.INPA_i = 1'b1;
      reset_n_i = 1'b1;
      step(2, 2, 1, 1, "first_cycle_rise");
      step(2, 2, 1, 1, "first_cycle_rise_2");
      step(2, 2, 1, 0, "first_cycle_rise_end");

      // delay history is discarded by reset
      do_reset();
      for (int i = 0; i < 3; i++) step(3, 2, 0, 0, $sformatf("history_lost[%0d]", i));

      // ---------------- maximal FUNC does not wrap ----------------
      step(2, 32'hFFFF_FFFF, 1, 1, "max_func_rise");
      for (int i = 0; i < 300; i++)
         step(2, 32'hFFFF_FFFF, 0, 1, $sformatf("max_func_hold[%0d]", i));

      // ---------------- randomized vs. model ----------------
      do_reset();
      mdl_reset();
      ra = 2'd0; rf = 32'd0; rin = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) ra = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)
            rf = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 40));
         if ($urandom_range(0, 2) == 0) rin = ~rin;
         rexp = mdl_step(ra, rf, rin);
         step(ra, rf, rin, rexp, $sformatf("random[%0d]", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/test_block.md
Name: test_block

Overview:
- Small single-bit processing block for the timing-test framework.
- It samples one bit input, INPA_i, and drives one registered bit output, OUT_o.
- The operating mode is selected by the 2-bit A word; the 32-bit FUNC word supplies a pulse width or delay.
- It is a self-contained leaf block clocked by the FPGA system clock and driven by test-vector stimulus.

Parameters:
- none

Ports:
- clk_i  input  1  system clock; all logic on its rising edge
- reset_n_i  input  1  asynchronous, active-low reset
- FUNC  input  32  pulse width (mode 2) or delay (mode 3, bits [4:0] only); other bits ignored in mode 3
- A  input  2  mode select: 0 pass, 1 invert, 2 pulse stretch, 3 delay
- INPA_i  input  1  data input bit
- OUT_o  output  1  registered result

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low (reset_n_i). All state is cleared while reset_n_i=0.
- Reset values: OUT_o=0, prev_inpa=0, pulse counter=0, 32-bit delay shift register=all zeros.
- Every cycle, prev_inpa <= INPA_i.
- Every cycle, regardless of mode, the shift register shifts in INPA_i: sr <= {sr[30:0], INPA_i}.
- Rising edge is defined as rise = INPA_i & ~prev_inpa.
  - Because prev_inpa resets to 0, INPA_i already high on the first cycle after reset release counts as a rising edge.
- Mode A=0: OUT_o <= INPA_i. Latency 1 cycle.
- Mode A=1: OUT_o <= ~INPA_i. Latency 1 cycle.
- Mode A=2 (pulse stretch):
  - On rise, counter <= max(FUNC,1) - 1 and OUT_o <= 1.
  - Otherwise, if counter != 0: counter decrements and OUT_o stays 1.
  - Otherwise OUT_o <= 0.
  - Result: OUT_o is high for exactly max(FUNC,1) cycles, starting 1 cycle after the edge sample.
  - A new rise while the pulse is active reloads the counter (retrigger), extending the pulse.
  - A FUNC change mid-pulse has no effect until the next rise.
  - FUNC=0xFFFFFFFF is legal: a 32-bit counter with no wrap.
- Mode A=3 (delay):
  - OUT_o <= sr[FUNC[4:0]]. Total latency from INPA_i to OUT_o is FUNC[4:0]+2 cycles (FUNC=0 gives 2).
  - FUNC[31:5] is ignored.
- Mode change (A differs from the previous cycle's A): counter is cleared that cycle and the new mode's rule applies immediately. The shift register is never cleared except by reset.
- FUNC and A are plain level inputs sampled every cycle. There is no write strobe or handshake.
- Reset asserted mid-pulse or mid-delay: OUT_o drops to 0 asynchronously. After release, all history is lost.
- No combinational path from any input to OUT_o.

Test Plan:
- Reset release, then A=0, INPA_i toggles at cycles 10 and 15 -> OUT_o follows with 1-cycle lag: 1 during cycles 11-15, 0 elsewhere; OUT_o=0 throughout reset.
- A=1, INPA_i held 0 -> OUT_o=1 from 1 cycle after A is set. INPA_i=1 at cycle 20 -> OUT_o=0 at cycle 21.
- A=2, FUNC=5, single 1-cycle INPA_i pulse at cycle 30 -> OUT_o=1 for cycles 31-35, 0 at 36. Repeat with FUNC=0 -> OUT_o high for cycle 31 only.
- A=2, FUNC=4, rises at cycles 40 and 42 -> OUT_o high cycles 41-46 (retrigger extends). Assert reset_n_i=0 at cycle 43 -> OUT_o=0 immediately.
- A=3, FUNC=3, INPA_i pulse at cycle 50 -> OUT_o pulse at cycle 55. FUNC=0x00000023 behaves identically (bits [31:5] ignored).
- A switched 2->0 mid-pulse (FUNC=10) -> OUT_o follows INPA_i from the next cycle and the counter is cleared. Switching back to 2 with no new rise -> OUT_o=0.
